// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// VGA raster timing generator. A clock divider turns clk into a pixel strobe.
// Horizontal and vertical counters walk the full raster (active + front
// porch + sync + back porch). Every output is driven straight from a flop,
// and the decoded outputs are computed from the next-state counts so they
// change on the same edge as the x/y they describe.
//
// Parameters
//   CLK_DIV                          clk cycles per pixel
//   H_ACTIVE, H_FP, H_SYNC, H_BP     horizontal timing in pixels
//   V_ACTIVE, V_FP, V_SYNC, V_BP     vertical timing in lines
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous reset, active low
//   enable       in   run control; low freezes all timing state
//   pix_tick     out  high for one clk per pixel, the cycle a new x is shown
//   x            out  horizontal count, 0..H_TOTAL-1
//   y            out  vertical count, 0..V_TOTAL-1
//   active       out  visible region (x < H_ACTIVE and y < V_ACTIVE)
//   hSync        out  horizontal sync, active low
//   vSync        out  vertical sync, active low
//   line_start   out  one-clk pulse on the cycle x first shows 0 after a wrap
//   frame_start  out  one-clk pulse on the cycle (x,y) first shows (0,0)
//   frame_count  out  frames completed, modulo 256
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hSync,
    output logic       vSync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // A divide-by-one still needs a one-bit counter that simply stays at 0.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;
    logic             div_wrap;
    logic             x_wrap;
    logic             y_wrap;
    logic             active_nxt;
    logic             hsync_nxt;
    logic             vsync_nxt;

    // Wrap conditions chain: a line wraps only on a pixel step, a frame
    // only on a line wrap. enable gates the whole chain, so with enable low
    // every next-state value equals the current one and all pulses are 0.
    always_comb begin
        div_wrap = enable && (div_cnt == DIV_LAST);
        x_wrap   = div_wrap && (x == X_LAST);
        y_wrap   = x_wrap && (y == Y_LAST);
    end

    always_comb begin
        div_nxt = div_cnt;
        x_nxt   = x;
        y_nxt   = y;
        if (enable) begin
            if (div_wrap) begin
                div_nxt = '0;
                if (x_wrap) begin
                    x_nxt = '0;
                    if (y_wrap) begin
                        y_nxt = '0;
                    end else begin
                        y_nxt = y + 10'd1;
                    end
                end else begin
                    x_nxt = x + 10'd1;
                end
            end else begin
                div_nxt = div_cnt + 1'b1;
            end
        end
    end

    // Decoding the next-state counts lets the registered flags line up
    // with the registered x/y they belong to.
    always_comb begin
        active_nxt = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
        hsync_nxt  = !((x_nxt >= HS_START) && (x_nxt < HS_END));
        vsync_nxt  = !((y_nxt >= VS_START) && (y_nxt < VS_END));
    end

    // Reset puts the raster at (0,0), which is inside the visible region
    // and outside both sync windows. The pulses stay low there: the first
    // line_start/frame_start comes from a genuine wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            x           <= '0;
            y           <= '0;
            active      <= 1'b1;
            hSync       <= 1'b1;
            vSync       <= 1'b1;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            div_cnt     <= div_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            active      <= active_nxt;
            hSync       <= hsync_nxt;
            vSync       <= vsync_nxt;
            pix_tick    <= div_wrap;
            line_start  <= x_wrap;
            frame_start <= y_wrap;
            if (y_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share clk/reset/enable: one with the default 640x480 timing
// (used for line-level checks) and one with a tiny raster (12x6 pixels) so
// that whole frames and the 256-frame counter wrap fit in a short run.
// The reference model derives everything from the number of enabled clk
// edges since reset, using plain division and modulo.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int D_DIV = 2;
    localparam int S_HA = 8, S_HF = 1, S_HS = 2, S_HB = 1;
    localparam int S_VA = 3, S_VF = 1, S_VS = 1, S_VB = 1;
    localparam int L_HA = 640, L_HF = 16, L_HS = 96, L_HB = 48;
    localparam int L_VA = 480, L_VF = 10, L_VS = 2, L_VB = 33;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;

    logic       s_pt, s_act, s_hs, s_vs, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;
    logic       d_pt, d_act, d_hs, d_vs, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;

    int total = 0;
    int bad = 0;
    int printed = 0;
    bit checking = 1'b0;

    int n_clk = 0;
    bit last_en = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(D_DIV),
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_small (
        .clk(clk), .reset(reset), .enable(enable),
        .pix_tick(s_pt), .x(s_x), .y(s_y), .active(s_act),
        .hSync(s_hs), .vSync(s_vs), .line_start(s_ls),
        .frame_start(s_fs), .frame_count(s_fc)
    );

    vga_timing_gen u_dflt (
        .clk(clk), .reset(reset), .enable(enable),
        .pix_tick(d_pt), .x(d_x), .y(d_y), .active(d_act),
        .hSync(d_hs), .vSync(d_vs), .line_start(d_ls),
        .frame_start(d_fs), .frame_count(d_fc)
    );

    typedef struct packed {
        int   x;
        int   y;
        int   fc;
        logic act;
        logic hs;
        logic vs;
        logic pt;
        logic ls;
        logic fs;
    } exp_t;

    // n enabled edges since reset -> pixel n/div; position and frame number
    // follow from the raster size. Pulses exist only right after an enabled
    // edge that completed a pixel.
    function automatic exp_t model(input int n, input bit le, input int dv,
                                   input int ha, input int hf, input int hsy, input int hb,
                                   input int va, input int vf, input int vsy, input int vb);
        exp_t e;
        int ht, vt, p;
        bit step;
        ht   = ha + hf + hsy + hb;
        vt   = va + vf + vsy + vb;
        p    = n / dv;
        e.x  = p % ht;
        e.y  = (p / ht) % vt;
        e.fc = (p / (ht * vt)) % 256;
        e.act = (e.x < ha) && (e.y < va);
        e.hs = !((e.x >= ha + hf) && (e.x < ha + hf + hsy));
        e.vs = !((e.y >= va + vf) && (e.y < va + vf + vsy));
        step = le && (n > 0) && ((n % dv) == 0);
        e.pt = step;
        e.ls = step && (e.x == 0);
        e.fs = step && (e.x == 0) && (e.y == 0);
        return e;
    endfunction

    task automatic cmp(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            if (printed < 40) begin
                printed++;
                $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, got, want);
            end
        end
    endtask

    task automatic cmp_inst(input string p, input exp_t e,
                            input int x, input int y, input int fc,
                            input logic act, input logic hs, input logic vs,
                            input logic pt, input logic ls, input logic fs);
        cmp({p, ".x"}, x, e.x);
        cmp({p, ".y"}, y, e.y);
        cmp({p, ".frame_count"}, fc, e.fc);
        cmp({p, ".active"}, int'(act), int'(e.act));
        cmp({p, ".hSync"}, int'(hs), int'(e.hs));
        cmp({p, ".vSync"}, int'(vs), int'(e.vs));
        cmp({p, ".pix_tick"}, int'(pt), int'(e.pt));
        cmp({p, ".line_start"}, int'(ls), int'(e.ls));
        cmp({p, ".frame_start"}, int'(fs), int'(e.fs));
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_clk   <= 0;
            last_en <= 1'b0;
        end else if (enable) begin
            n_clk   <= n_clk + 1;
            last_en <= 1'b1;
        end else begin
            last_en <= 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (checking) begin
            e = model(n_clk, last_en, D_DIV, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
            cmp_inst("small", e, int'(s_x), int'(s_y), int'(s_fc),
                     s_act, s_hs, s_vs, s_pt, s_ls, s_fs);
            e = model(n_clk, last_en, D_DIV, L_HA, L_HF, L_HS, L_HB, L_VA, L_VF, L_VS, L_VB);
            cmp_inst("dflt", e, int'(d_x), int'(d_y), int'(d_fc),
                     d_act, d_hs, d_vs, d_pt, d_ls, d_fs);
        end
    end

    initial begin
        int d_hs_low, d_act_low, d_pt_cnt, s_vs_low, s_ls_cnt, s_fs_cnt, fs_seen;
        bit found;
        d_hs_low = 0; d_act_low = 0; d_pt_cnt = 0;
        s_vs_low = 0; s_ls_cnt = 0; s_fs_cnt = 0; fs_seen = 0;

        checking = 1'b1;
        enable   = 1'b1;
        repeat (3) @(negedge clk);

        // Held in reset: (0,0) values.
        cmp("rst.d_x", int'(d_x), 0);
        cmp("rst.d_y", int'(d_y), 0);
        cmp("rst.d_active", int'(d_act), 1);
        cmp("rst.d_hSync", int'(d_hs), 1);
        cmp("rst.d_vSync", int'(d_vs), 1);
        cmp("rst.s_frame_count", int'(s_fc), 0);
        reset = 1'b1;

        // Line and frame from release.
        for (int k = 1; k <= 1600; k++) begin
            @(negedge clk);
            if (!d_hs) d_hs_low++;
            if (!d_act) d_act_low++;
            if (d_pt) d_pt_cnt++;
            if (k <= 144) begin
                if (!s_vs) s_vs_low++;
                if (s_ls) s_ls_cnt++;
                if (s_fs) s_fs_cnt++;
            end
            if (k == 1) cmp("d_pix_tick@1", int'(d_pt), 0);
            if (k == 2) cmp("d_pix_tick@2", int'(d_pt), 1);
            if (k == 1311) cmp("d_hSync@1311", int'(d_hs), 1);
            if (k == 1312) begin
                cmp("d_x@1312", int'(d_x), 656);
                cmp("d_hSync@1312", int'(d_hs), 0);
            end
            if (k == 143) cmp("s_frame_count@143", int'(s_fc), 0);
            if (k == 144) begin
                cmp("s_frame_start@144", int'(s_fs), 1);
                cmp("s_frame_count@144", int'(s_fc), 1);
            end
            if (k == 1598) cmp("d_x@1598", int'(d_x), 799);
            if (k == 1599) cmp("d_line_start@1599", int'(d_ls), 0);
            if (k == 1600) begin
                cmp("d_x@1600", int'(d_x), 0);
                cmp("d_line_start@1600", int'(d_ls), 1);
                cmp("d_y@1600", int'(d_y), 1);
            end
        end
        cmp("d_hSync_low_clks", d_hs_low, 192);
        cmp("d_active_low_clks", d_act_low, 320);
        cmp("d_pix_tick_count", d_pt_cnt, 800);
        cmp("s_vSync_low_clks", s_vs_low, 24);
        cmp("s_line_start_count", s_ls_cnt, 6);
        cmp("s_frame_start_count", s_fs_cnt, 1);

        // Freeze for 37 clks right after x became 5.
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_x == 10'd5 && s_pt) begin
                found = 1'b1;
                break;
            end
        end
        cmp("freeze_point_found", int'(found), 1);
        enable = 1'b0;
        for (int k = 0; k < 37; k++) begin
            @(negedge clk);
            cmp("frozen.s_x", int'(s_x), 5);
            cmp("frozen.s_pix_tick", int'(s_pt), 0);
        end
        enable = 1'b1;
        @(negedge clk);
        cmp("resume1.s_x", int'(s_x), 5);
        cmp("resume1.s_pix_tick", int'(s_pt), 0);
        @(negedge clk);
        cmp("resume2.s_x", int'(s_x), 6);
        cmp("resume2.s_pix_tick", int'(s_pt), 1);

        // Reset mid-frame inside both sync windows.
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_x == 10'd10 && s_y == 10'd4) begin
                found = 1'b1;
                break;
            end
        end
        cmp("sync_point_found", int'(found), 1);
        cmp("pre_rst.s_hSync", int'(s_hs), 0);
        cmp("pre_rst.s_vSync", int'(s_vs), 0);
        #2 reset = 1'b0;
        #1;
        cmp("async_rst.s_x", int'(s_x), 0);
        cmp("async_rst.s_y", int'(s_y), 0);
        cmp("async_rst.s_active", int'(s_act), 1);
        cmp("async_rst.s_hSync", int'(s_hs), 1);
        cmp("async_rst.s_vSync", int'(s_vs), 1);
        cmp("async_rst.s_pix_tick", int'(s_pt), 0);
        cmp("async_rst.s_line_start", int'(s_ls), 0);
        cmp("async_rst.s_frame_start", int'(s_fs), 0);
        cmp("async_rst.s_frame_count", int'(s_fc), 0);
        cmp("async_rst.d_x", int'(d_x), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // 256 frames: first frame_start 144 clks after release, then wrap.
        for (int k = 1; k <= 256 * 144 + 20; k++) begin
            @(negedge clk);
            if (s_fs) begin
                fs_seen++;
                if (fs_seen == 1) cmp("first_frame_start_clk", k, 144);
                if (fs_seen == 255) cmp("frame_count@255", int'(s_fc), 255);
                if (fs_seen == 256) begin
                    cmp("frame_count_wrap", int'(s_fc), 0);
                    break;
                end
            end
        end
        cmp("frames_seen", fs_seen, 256);

        @(negedge clk);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
